// File: rtl/pipe_add.sv
// pipe_add: pipelined ripple-carry adder with a valid/ready handshake.
//
// The WIDTH-bit addition is cut into NSEG = WIDTH/SEG carry segments. An
// input layer captures the operands; each following layer adds one SEG-bit
// segment and registers its carry for the next layer. The upper operand
// segments ride along in skew registers, and the lower sum segments that are
// already finished ride along in a partial-sum register. A result is
// therefore visible NSEG edges after the edge that accepted its operands.
//
// WIDTH must be an integer multiple of SEG, and WIDTH must be at least 2.
//
// Compile-time option PIPE_ADD_SAT_EN: when defined, a signed overflow
// clamps sum to the largest or smallest two's-complement value. The clamp
// follows the sign of a. c_out and ovf always report the raw result.
//
// Handshake: a transfer happens on a rising edge where valid && ready. Every
// layer shares one advance enable, adv = !out_valid || out_ready.
// in_ready equals adv and is built only from registered state and
// out_ready, so no path runs from in_valid to any output. When adv is low,
// every layer holds, bubbles included. Once out_valid is high, sum, c_out and
// ovf stay stable until the result is taken.

module pipe_add #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG;

  // Layer 0 is the operand capture layer. Layer k (1..NSEG) holds the
  // result after segment k-1 has been added.
  logic [NSEG:0]    v_q;
  logic [NSEG:0]    c_q;
  logic [WIDTH-1:0] a_q [0:NSEG];
  logic [WIDTH-1:0] b_q [0:NSEG];
  logic [WIDTH-1:0] s_q [0:NSEG];

  // Combinational segment adders that feed layers 1..NSEG.
  logic [SEG:0]     seg_res [1:NSEG];
  logic [WIDTH-1:0] s_nxt   [1:NSEG];

  logic             adv;
  logic [WIDTH-1:0] raw_sum;
  logic             a_msb;
  logic             b_msb;

  // Only the operand MSBs are consumed once the last segment has been added.
  logic             unused_skew;
  assign unused_skew = ^{a_q[NSEG][WIDTH-2:0], b_q[NSEG][WIDTH-2:0]};

  assign out_valid = v_q[NSEG];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // One SEG-bit ripple per layer; merge it into the partial sum carried along.
  always_comb begin
    for (int k = 1; k <= NSEG; k++) begin
      seg_res[k] = {1'b0, a_q[k-1][(k-1)*SEG +: SEG]}
                 + {1'b0, b_q[k-1][(k-1)*SEG +: SEG]}
                 + {{SEG{1'b0}}, c_q[k-1]};
      s_nxt[k]   = s_q[k-1];
      s_nxt[k][(k-1)*SEG +: SEG] = seg_res[k][SEG-1:0];
    end
  end

  // Pipeline registers: every layer shifts together when adv is high.
  // Data registers load only behind a valid entry, so bubbles never disturb
  // the held output data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= NSEG; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      v_q[0] <= in_valid;
      if (in_valid) begin
        a_q[0] <= a;
        b_q[0] <= b;
        c_q[0] <= c_in;
        s_q[0] <= '0;
      end
      for (int k = 1; k <= NSEG; k++) begin
        v_q[k] <= v_q[k-1];
        if (v_q[k-1]) begin
          a_q[k] <= a_q[k-1];
          b_q[k] <= b_q[k-1];
          c_q[k] <= seg_res[k][SEG];
          s_q[k] <= s_nxt[k];
        end
      end
    end
  end

  // Final-layer flags. Overflow uses the skewed operand MSBs.
  always_comb begin
    raw_sum = s_q[NSEG];
    a_msb   = a_q[NSEG][WIDTH-1];
    b_msb   = b_q[NSEG][WIDTH-1];
    c_out   = c_q[NSEG];
    ovf     = (a_msb == b_msb) && (raw_sum[WIDTH-1] != a_msb);
  end

`ifdef PIPE_ADD_SAT_EN
  // Clamp on signed overflow toward the sign of a, with no added latency.
  always_comb begin
    sum = raw_sum;
    if (ovf) begin
      sum = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  // Modular result passes straight through.
  always_comb begin
    sum = raw_sum;
  end
`endif

endmodule

// File: tb/tb_pipe_add.sv
// tb_pipe_add: self-checking bench for pipe_add at WIDTH=16, SEG=4.
// Expected results are queued when operands are accepted and popped when a
// result leaves the adder.
module tb_pipe_add;

  localparam int W    = 16;
  localparam int S    = 4;
  localparam int NSEG = W / S;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] cur_exp;
  logic         bp_en = 1'b0;
  logic         held = 1'b0;
  logic [W+1:0] held_val;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  vec_t vecs[8];

  pipe_add #(.WIDTH(W), .SEG(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input logic ok, input string name,
                       input logic [W+1:0] act, input logic [W+1:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Full-width reference adder: {sum, c_out, ovf}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic ci);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         o;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    s    = full[W-1:0];
    o    = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
`ifdef PIPE_ADD_SAT_EN
    if (o) s = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {s, full[W], o};
  endfunction

  // Random backpressure, changed just after each active edge.
  always @(posedge clk) begin
    #1;
    out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard and handshake monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [W+1:0] got;
    logic [W+1:0] e;
    got = {sum, c_out, ovf};
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      check(in_ready === (!out_valid || out_ready), "in_ready",
            {{W{1'b0}}, 1'b0, in_ready}, {{W{1'b0}}, 1'b0, (!out_valid || out_ready)});
      if (held)
        check(out_valid === 1'b1 && got === held_val, "stall_hold", got, held_val);
      held     = out_valid && !out_ready;
      held_val = got;
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_result", got, '0);
        end else begin
          e = exp_q.pop_front();
          check(got === e, "result", got, e);
        end
      end
    end
  end

  // Driver: offer one operand set and hold it until accepted.
  // Called just after an active edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic [W+1:0] e);
    int n;
    a = x; b = y; c_in = ci; cur_exp = e; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check(1'b0, "send_timeout", '0, '1);
    @(posedge clk);
    #1;
  endtask

  // Single operand set into an idle pipe; checks the exact output latency.
  task automatic single_op(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic ci, input logic [W+1:0] e);
    a = x; b = y; c_in = ci; cur_exp = e; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k <= NSEG; k++) begin
      @(negedge clk);
      check(out_valid === (k == NSEG), "latency",
            {{W{1'b0}}, 1'b0, out_valid}, {{W{1'b0}}, 1'b0, 1'(k == NSEG)});
      if (k < NSEG) @(posedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    bp_en    = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(exp_q.size() == 0, "drain", W'(exp_q.size()), '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
`ifdef PIPE_ADD_SAT_EN
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1};
`else
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
`endif
    vecs[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; cur_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check(out_valid === 1'b0, "rst_out_valid", {17'd0, out_valid}, '0);
    check({sum, c_out, ovf} === '0, "rst_outputs", {sum, c_out, ovf}, '0);
    check(in_ready === 1'b1, "rst_in_ready", {17'd0, in_ready}, 18'd1);
    @(posedge clk);
    #1;

    // Single op with exact latency, then the table back-to-back.
    single_op(vecs[0].a, vecs[0].b, vecs[0].ci, {vecs[0].s, vecs[0].c, vecs[0].o});
    for (int i = 1; i < 8; i++)
      send(vecs[i].a, vecs[i].b, vecs[i].ci, {vecs[i].s, vecs[i].c, vecs[i].o});
    drain();

    // Same table under random backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 8; i++)
      send(vecs[i].a, vecs[i].b, vecs[i].ci, {vecs[i].s, vecs[i].c, vecs[i].o});
    drain();

    // 100 random ops with bubbles and backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         ci;
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      x  = W'($urandom());
      y  = W'($urandom());
      ci = 1'($urandom_range(0, 1));
      send(x, y, ci, model(x, y, ci));
    end
    drain();

    // Reset mid-flight: three ops in the pipe, then a one-cycle reset.
    send(16'h0001, 16'h0002, 1'b0, model(16'h0001, 16'h0002, 1'b0));
    send(16'h1111, 16'h2222, 1'b1, model(16'h1111, 16'h2222, 1'b1));
    send(16'hABCD, 16'h1234, 1'b0, model(16'hABCD, 16'h1234, 1'b0));
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check(out_valid === 1'b0, "flush_out_valid", {17'd0, out_valid}, '0);
      if (k == 0)
        check({sum, c_out, ovf} === '0, "flush_outputs", {sum, c_out, ovf}, '0);
      @(posedge clk);
      #1;
    end
    single_op(16'h7FFF, 16'h7FFF, 1'b1, model(16'h7FFF, 16'h7FFF, 1'b1));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_add.md
# pipe_add

Parametrised, pipelined ripple-carry adder with valid/ready handshake. Generalises the single-bit half/full adder cells into a WIDTH-bit adder split into SEG-bit carry segments, one segment per pipeline stage, for the FIR accumulation path where full-width single-cycle carry chains miss timing. Sustains one addition per clock under no backpressure and stalls cleanly under backpressure. Optional signed saturation is set at compile time.

## Interface
- WIDTH, 16, operand/sum width in bits; must be an integer multiple of SEG.
- SEG, 4, carry segment width in bits; NSEG = WIDTH/SEG pipeline stages, NSEG ≥ 1.
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a, b, c_in are valid this cycle.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry into bit 0.
- out_valid  out  1  sum, c_out and ovf are valid.
- out_ready  in  1  downstream accepts the result this cycle.
- sum  out  WIDTH  result.
- c_out  out  1  unsigned carry out of bit WIDTH-1; raw, never saturated.
- ovf  out  1  two's-complement overflow of a+b+c_in.

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv, driven combinationally from the registered out_valid and out_ready. No combinational path from in_valid to any output.
- Stage k (0..NSEG-1) adds a[k*SEG +: SEG] + b[k*SEG +: SEG] + carry_k. carry_0 = c_in. carry_k = registered carry out of stage k-1. Exactly one SEG-bit ripple per stage.
- Each stage has a valid bit, a skew register for the not-yet-added upper operand segments, and a register for the already-computed lower sum segments. Stage valid and data registers load only when adv = 1. When adv = 0, every stage holds, including bubbles.
- Final stage: c_out = carry out of bit WIDTH-1. ovf = (a[W-1] == b[W-1]) && (raw_sum[W-1] != a[W-1]), using the skewed operand MSBs.
- Arithmetic is modular 2^WIDTH unless saturation is enabled (see Configuration).
- Reset: all stage valid bits, data, carry and skew registers clear. Outputs after reset: out_valid=0, sum=0, c_out=0, ovf=0, in_ready=1.
- Reset mid-operation flushes all in-flight results. No result from before reset ever appears at the output.

## Timing
- Latency: operands accepted at edge t → out_valid=1 with their result after edge t+NSEG (4 cycles at default).
- Throughput: 1 result per cycle while out_ready=1. Results leave in acceptance order.
- Backpressure: while out_valid=1 && out_ready=0, sum/c_out/ovf stay stable, in_ready=0, and no operand is lost or duplicated.
- Simultaneous out transfer and in transfer in the same cycle is legal, and the pipeline shifts by one.
- Bubbles (in_valid=0 while adv=1) propagate as invalid stages and do not stall.
- NSEG=1 degenerates to a single registered adder with the same handshake.

## Configuration
- PIPE_ADD_SAT_EN defined: on ovf=1, sum saturates to 2^(W-1)-1 if a[W-1]=0, or to -2^(W-1) if a[W-1]=1. Saturation is applied combinationally in the final stage and adds no latency. ovf and c_out are unchanged.
- PIPE_ADD_SAT_EN undefined: sum is the raw modular result. ovf is still reported.

## Test plan
- Reset then idle: rst=1 for 2 cycles → out_valid=0, sum=0, c_out=0, ovf=0, in_ready=1.
- Single op, W=16/SEG=4: a=0x00FF, b=0x0001, c_in=0, accepted at edge t → after edge t+4: sum=0x0100, c_out=0, ovf=0. This checks carry across segments 1→2.
- Full carry chain: a=0xFFFF, b=0x0000, c_in=1 → sum=0x0000, c_out=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001 → ovf=1, c_out=0. sum=0x8000 without the macro, sum=0x7FFF with PIPE_ADD_SAT_EN. Also a=0x8000, b=0xFFFF → ovf=1, c_out=1, and sum=0x8000 with the macro.
- Streaming with backpressure: 100 random back-to-back ops, out_ready toggled randomly → output sequence matches the reference model in order. No loss or duplication. Outputs stay stable during stalls.
- Reset mid-flight: accept 3 ops, assert rst for 1 cycle → out_valid stays 0 until new operands are accepted. The first new result appears exactly NSEG cycles after its acceptance.
